// File: rtl/rnn_seq_serializer.sv
// rnn_seq_serializer: snapshots a parallel RNN result vector and streams it one element per beat
// with valid/ready and last. Define RNN_SER_BACK_TO_BACK_EN to allow a new capture on the final beat.
module rnn_seq_serializer #(
  parameter int DATA_WIDTH      = 16,
  parameter int SEQUENCE_LENGTH = 32,
  parameter int IDX_W           = $clog2(SEQUENCE_LENGTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seq_valid,
  output logic                  seq_ready,
  input  logic [DATA_WIDTH-1:0] seq_data [SEQUENCE_LENGTH-1:0],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [IDX_W-1:0]      out_index,
  output logic                  busy,
  output logic                  seq_done,
  output logic [15:0]           seq_count
);
  typedef enum logic {IDLE, STREAM} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQUENCE_LENGTH - 1);
  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_q [SEQUENCE_LENGTH-1:0];
  logic [DATA_WIDTH-1:0] data_d [SEQUENCE_LENGTH-1:0];
  logic                  done_q, done_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  xfer, cap;
  assign out_valid = state_q == STREAM;
  assign busy      = out_valid;
  assign out_index = idx_q;
  assign out_data  = data_q[idx_q];
  assign out_last  = out_valid && idx_q == LAST_IDX;
  assign seq_done  = done_q;
  assign seq_count = cnt_q;
  assign xfer      = out_valid && out_ready;
`ifdef RNN_SER_BACK_TO_BACK_EN
  assign seq_ready = rst_n && (!out_valid || (xfer && out_last));
`else
  assign seq_ready = rst_n && !out_valid;
`endif
  assign cap = seq_valid && seq_ready;
  // next state: capture wins over the final-beat return to IDLE so back-to-back stays in STREAM
  always_comb begin
    done_d  = xfer && out_last;
    state_d = cap ? STREAM : done_d ? IDLE : state_q;
    idx_d   = (cap || done_d) ? '0 : xfer ? idx_q + IDX_W'(1) : idx_q;
    cnt_d   = cnt_q + 16'(done_d);
    data_d  = data_q;
    if (cap) data_d = seq_data;
  end
  // state register with synchronous active-low reset clearing the snapshot buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '{default: '0};
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_rnn_seq_serializer.sv
// tb_rnn_seq_serializer: directed checks of capture, streaming, backpressure, reset abort, back-to-back and count wrap
module tb_rnn_seq_serializer;
  localparam int DW = 16;
  localparam int SL = 4;
  localparam int IW = 2;
`ifdef RNN_SER_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  typedef logic [15:0] vec_t [4];
  logic          clk = 1'b0;
  logic          rst_n, seq_valid, seq_ready, out_valid, out_ready, out_last, busy, seq_done;
  logic [DW-1:0] seq_data [SL-1:0];
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_index;
  logic [15:0]   seq_count;
  int            checks = 0;
  int            errors = 0;
  vec_t          s_a, s_aa, s_55, s_c, s_d, s_x, s_y;
  int            no_st [4];
  int            bp_st [4];

  rnn_seq_serializer #(.DATA_WIDTH(DW), .SEQUENCE_LENGTH(SL)) dut (
    .clk(clk), .rst_n(rst_n), .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_data(seq_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_index(out_index), .busy(busy), .seq_done(seq_done), .seq_count(seq_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input vec_t s);
    for (int i = 0; i < SL; i++) seq_data[i] = s[i];
  endtask

  task automatic start(input vec_t s);
    drive(s);
    seq_valid = 1'b1;
    #1;
    chk("ready_idle", 32'(seq_ready), 1);
    tick();
    seq_valid = 1'b0;
  endtask

  task automatic recv(input vec_t e, input int st [4]);
    for (int i = 0; i < SL; i++) begin
      out_ready = 1'b0;
      #1;
      for (int s = 0; s < st[i]; s++) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(e[i]));
        chk("stall_index", 32'(out_index), i);
        chk("stall_ready", 32'(seq_ready), 0);
        tick();
        #1;
      end
      out_ready = 1'b1;
      #1;
      chk("valid", 32'(out_valid), 1);
      chk("busy", 32'(busy), 1);
      chk("data", 32'(out_data), 32'(e[i]));
      chk("index", 32'(out_index), i);
      chk("last", 32'(out_last), 32'(i == SL - 1));
      chk("ready_stream", 32'(seq_ready), 32'(B2B && i == SL - 1));
      chk("no_done", 32'(seq_done), 0);
      tick();
    end
  endtask

  initial begin
    s_a  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    s_aa = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
    s_55 = '{16'h5555, 16'h5555, 16'h5555, 16'h5555};
    s_c  = '{16'h0021, 16'h0022, 16'h0023, 16'h0024};
    s_d  = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
    s_x  = '{16'h0031, 16'h0032, 16'h0033, 16'h0034};
    s_y  = '{16'h0041, 16'h0042, 16'h0043, 16'h0044};
    no_st = '{0, 0, 0, 0};
    bp_st = '{0, 3, 3, 0};
    rst_n = 1'b0; seq_valid = 1'b0; out_ready = 1'b0;
    drive(s_55);
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(seq_done), 0);
    chk("rst_count", 32'(seq_count), 0);
    chk("rst_ready", 32'(seq_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(seq_ready), 1);
    // basic stream
    start(s_a);
    recv(s_a, no_st);
    chk("basic_done", 32'(seq_done), 1);
    chk("basic_count", 32'(seq_count), 1);
    chk("basic_idle", 32'(out_valid), 0);
    // backpressure
    start(s_a);
    chk("done_one_pulse", 32'(seq_done), 0);
    recv(s_a, bp_st);
    chk("bp_done", 32'(seq_done), 1);
    chk("bp_count", 32'(seq_count), 2);
    // snapshot isolation
    start(s_aa);
    drive(s_55);
    recv(s_aa, no_st);
    chk("snap_done", 32'(seq_done), 1);
    chk("snap_count", 32'(seq_count), 3);
    // reset mid-stream
    start(s_c);
    out_ready = 1'b1;
    tick();
    tick();
    chk("mid_index", 32'(out_index), 2);
    chk("mid_data", 32'(out_data), 16'h0023);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_count", 32'(seq_count), 0);
    chk("abort_done", 32'(seq_done), 0);
    rst_n = 1'b1;
    tick();
    chk("abort_done2", 32'(seq_done), 0);
    chk("abort_count2", 32'(seq_count), 0);
    start(s_d);
    recv(s_d, no_st);
    chk("post_abort_done", 32'(seq_done), 1);
    chk("post_abort_count", 32'(seq_count), 1);
    // back-to-back with seq_valid held
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start(s_x);
    seq_valid = 1'b1;
    drive(s_y);
    recv(s_x, no_st);
    chk("b2b_done", 32'(seq_done), 1);
    chk("b2b_gap", 32'(out_valid), 32'(B2B));
    if (!B2B) tick();
    seq_valid = 1'b0;
    recv(s_y, no_st);
    chk("b2b_done2", 32'(seq_done), 1);
    chk("b2b_count", 32'(seq_count), 2);
    // counter wrap
    tick();
    dut.cnt_q = 16'hFFFF;
    #1;
    chk("wrap_preload", 32'(seq_count), 16'hFFFF);
    start(s_a);
    recv(s_a, no_st);
    chk("wrap_done", 32'(seq_done), 1);
    chk("wrap_count", 32'(seq_count), 0);
    tick();
    chk("wrap_done_end", 32'(seq_done), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
